cpu_fighter_ctrl: RTL
=====================

// Module: cpu_fighter_ctrl
// PURPOSE
//  Computer-controlled opponent: drives a player controller's keycode input the way a keyboard would.
//  It reads both fighters' positions and attack flags, then emits one keycode per frame on keycodes[7:0].
//  Sits between the fighter pair and the player controller in 1-player mode, in place of the USB keycode source.
// PARAMETERS
//  ATTACK_RANGE    16   gap in pixels at or below which the CPU attacks or guards
//  HOLD_FRAMES      6   frames an attack key (P/K) is held
//  COOLDOWN_FRAMES 10   frames with keycode 0 after an attack or guard (base value)
//  GUARD_FRAMES     8   minimum frames S is held once guarding starts
//  RETREAT_FRAMES  12   frames spent moving away after being hit
//  WALL_L / WALL_R 53 / 550   arena X limits used for the wall-jump check
// PORTS
//  frame_clk      in   1   frame clock
//  Reset          in   1   asynchronous, active-high
//  game_mode      in   3   CPU is active only for 3'b001 or 3'b010
//  p_lose         in   1   CPU fighter has lost; forces idle
//  hit            in   1   CPU fighter was struck this frame
//  self_PosX      in  10   CPU fighter X position
//  self_SizeX     in  10   CPU fighter width
//  other_PosX     in  10   opponent X position
//  other_SizeX    in  10   opponent width
//  other_punch    in   1   opponent is punching
//  other_kick     in   1   opponent is kicking
//  keycodes       out 32   [7:0] = generated key; [31:8] = 0 always
//  ai_state       out  3   current state encoding (debug)
// BEHAVIOUR
//  Key codes: W=8'h1A, S=8'h16, D=8'h07 (right), A=8'h04 (left), K=8'h0E, P=8'h13; 8'h00 = no key.
//  - All outputs are registered. A decision made at frame_clk edge n uses inputs sampled at edge n.
//    The resulting key is visible right after edge n (1-frame latency).
//  - Reset: keycodes = 0, ai_state = IDLE, frame counter = 0, attack toggle = 0, LFSR = 16'hACE1.
//    Reset asserted mid-operation aborts any held key immediately.
//  - active = (game_mode == 3'b001 || game_mode == 3'b010) && !p_lose.
//    When !active: next state = IDLE and keycode = 0, overriding everything else.
//  - Side: left = self_PosX < other_PosX.
//    Gap is computed in 11 bits:
//      left:  other_PosX - (self_PosX + self_SizeX)
//      right: self_PosX - (other_PosX + other_SizeX)
//    Negative results (overlap) saturate to 0.
//  - "toward" = D if left, else A. "away" = A if left, else D.
//  - threat = (other_punch || other_kick) && gap <= ATTACK_RANGE.
//  - States and encodings: IDLE 0, APPROACH 1, ATTACK 2, RECOVER 3, GUARD 4, RETREAT 5, JUMP 6.
//  - Counter is 8 bits. It loads on every state entry and decrements by 1 per frame, saturating at 0.
//  - Transition priority, highest first: !active > hit (-> RETREAT) > threat from APPROACH (-> GUARD) > per-state rules below.
//  - IDLE:     key 0. If active -> APPROACH.
//  - APPROACH: key = toward. If gap <= ATTACK_RANGE -> ATTACK.
//  - ATTACK:   counter loads HOLD_FRAMES. Key is P or K (selection rule below), held constant for the whole state.
//              When counter reaches 0 -> RECOVER.
//  - RECOVER:  key 0 (the release the controller needs to clear punch/kick).
//              Counter loads the cooldown value. When counter reaches 0 -> APPROACH.
//  - GUARD:    key S. Counter loads GUARD_FRAMES.
//              When counter == 0 && !(other_punch || other_kick) -> RECOVER.
//  - RETREAT:  key = away. Counter loads RETREAT_FRAMES.
//              If self_PosX <= WALL_L + 3 or self_PosX + self_SizeX >= WALL_R - 3 -> JUMP.
//              Otherwise, when counter reaches 0 -> APPROACH.
//  - JUMP:     key W for exactly 1 frame, then -> RECOVER.
//  - hit while already in RETREAT reloads RETREAT_FRAMES.
//  - hit while in JUMP is ignored; W must last its 1 frame.
//  - Every state change inserts no extra gap frame; the new key appears on the next edge.
// CONFIGURATION
//  AI_RANDOM_EN defined:
//    - 16-bit Galois LFSR, taps 16'hB400, advances every frame while active.
//    - ATTACK key is chosen on ATTACK entry: K if lfsr[0] == 1, else P.
//    - Cooldown = COOLDOWN_FRAMES + lfsr[2:1].
//  AI_RANDOM_EN undefined:
//    - No LFSR.
//    - ATTACK key alternates, starting with P after reset; the toggle flips on each ATTACK entry.
//    - Cooldown = COOLDOWN_FRAMES exactly.
// TESTING
//  1. game_mode=0, then 3'b001; self=50/64, other=400/64 -> keycode 0, then 8'h07 from the 2nd edge after enable.
//  2. self 300/64, other 370 (gap 6) -> ATTACK: 8'h13 for 6 frames, then 8'h00 for 10 frames, then 8'h07 (macro off).
//  3. gap 6, other_punch=1 while in APPROACH -> 8'h16 for >= 8 frames; held until other_punch drops, then 8'h00.
//  4. hit pulse with self left of other -> 8'h04 for 12 frames; with self_PosX=55 -> 8'h1A for 1 frame, then 8'h00.
//  5. p_lose=1 mid-ATTACK -> keycode 0 and ai_state=0 next edge; async Reset mid-hold -> keycode 0 with no clock edge.
//  6. Run twice, once with AI_RANDOM_EN undefined and once defined:
//     - undefined: four successive attacks give P, K, P, K;
//     - defined: key and cooldown match a reference LFSR model seeded 16'hACE1.

Source files
------------

// File: rtl/cpu_fighter_ctrl.sv
// cpu_fighter_ctrl: CPU opponent that emits one keyboard keycode per frame from fighter positions and attack flags.
// Define AI_RANDOM_EN for LFSR-driven attack choice and jittered cooldown; otherwise P/K alternate with fixed cooldown.
module cpu_fighter_ctrl #(
    parameter int ATTACK_RANGE    = 16,
    parameter int HOLD_FRAMES     = 6,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int GUARD_FRAMES    = 8,
    parameter int RETREAT_FRAMES  = 12,
    parameter int WALL_L          = 53,
    parameter int WALL_R          = 550
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [2:0]  game_mode,
    input  logic        p_lose,
    input  logic        hit,
    input  logic [9:0]  self_PosX,
    input  logic [9:0]  self_SizeX,
    input  logic [9:0]  other_PosX,
    input  logic [9:0]  other_SizeX,
    input  logic        other_punch,
    input  logic        other_kick,
    output logic [31:0] keycodes,
    output logic [2:0]  ai_state
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] APPROACH = 3'd1;
    localparam logic [2:0] ATTACK   = 3'd2;
    localparam logic [2:0] RECOVER  = 3'd3;
    localparam logic [2:0] GUARD    = 3'd4;
    localparam logic [2:0] RETREAT  = 3'd5;
    localparam logic [2:0] JUMP     = 3'd6;
    localparam logic [7:0] K_W = 8'h1A;
    localparam logic [7:0] K_S = 8'h16;
    localparam logic [7:0] K_D = 8'h07;
    localparam logic [7:0] K_A = 8'h04;
    localparam logic [7:0] K_K = 8'h0E;
    localparam logic [7:0] K_P = 8'h13;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  key_q, key_d;
    logic [7:0]  atk_key_q, atk_key_d;
    logic        active, left, atk, threat, near, wall, enter;
    logic [10:0] self_end, other_end, gap;
    logic [11:0] diff;
    logic [7:0]  toward, away, pick, cool;

    assign active    = (game_mode == 3'b001 || game_mode == 3'b010) && !p_lose;
    assign left      = self_PosX < other_PosX;
    assign self_end  = {1'b0, self_PosX} + {1'b0, self_SizeX};
    assign other_end = {1'b0, other_PosX} + {1'b0, other_SizeX};
    // Overlap shows up as a borrow into bit 11 and clamps the gap to zero.
    assign diff      = left ? {2'b0, other_PosX} - {1'b0, self_end} : {2'b0, self_PosX} - {1'b0, other_end};
    assign gap       = diff[11] ? 11'd0 : diff[10:0];
    assign near      = gap <= 11'(ATTACK_RANGE);
    assign atk       = other_punch || other_kick;
    assign threat    = atk && near;
    assign wall      = {1'b0, self_PosX} <= 11'(WALL_L + 3) || self_end >= 11'(WALL_R - 3);
    assign toward    = left ? K_D : K_A;
    assign away      = left ? K_A : K_D;

`ifdef AI_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign pick   = lfsr_q[0] ? K_K : K_P;
    assign cool   = 8'(COOLDOWN_FRAMES) + {6'd0, lfsr_q[2:1]};
    assign lfsr_d = !active ? lfsr_q : ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000));
    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) lfsr_q <= 16'hACE1;
        else lfsr_q <= lfsr_d;
`else
    logic tog_q, tog_d;
    assign pick  = tog_q ? K_K : K_P;
    assign cool  = 8'(COOLDOWN_FRAMES);
    assign tog_d = (enter && state_d == ATTACK) ? ~tog_q : tog_q;
    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) tog_q <= 1'b0;
        else tog_q <= tog_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = APPROACH;
            APPROACH: state_d = near ? ATTACK : APPROACH;
            ATTACK:   state_d = (cnt_q == 8'd0) ? RECOVER : ATTACK;
            RECOVER:  state_d = (cnt_q == 8'd0) ? APPROACH : RECOVER;
            GUARD:    state_d = (cnt_q == 8'd0 && !atk) ? RECOVER : GUARD;
            RETREAT:  state_d = wall ? JUMP : (cnt_q == 8'd0) ? APPROACH : RETREAT;
            JUMP:     state_d = RECOVER;
            default:  state_d = IDLE;
        endcase
        if (state_q == APPROACH && threat) state_d = GUARD;
        if (hit && state_q != JUMP) state_d = RETREAT;
        if (!active) state_d = IDLE;
    end

    // A repeated hit while retreating counts as a fresh entry so the retreat timer restarts.
    assign enter = (state_d != state_q) || (state_d == RETREAT && hit);

    always_comb begin
        cnt_d = !enter ? ((cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1) :
                state_d == ATTACK  ? 8'(HOLD_FRAMES - 1) :
                state_d == RECOVER ? cool - 8'd1 :
                state_d == GUARD   ? 8'(GUARD_FRAMES - 1) :
                state_d == RETREAT ? 8'(RETREAT_FRAMES - 1) : 8'd0;
        atk_key_d = (enter && state_d == ATTACK) ? pick : atk_key_q;
        key_d = !active              ? 8'h00 :
                state_q == APPROACH  ? toward :
                state_q == ATTACK    ? atk_key_q :
                state_q == GUARD     ? K_S :
                state_q == RETREAT   ? away :
                state_q == JUMP      ? K_W : 8'h00;
    end

    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            key_q     <= 8'h00;
            atk_key_q <= K_P;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            atk_key_q <= atk_key_d;
        end

    assign keycodes = {24'd0, key_q};
    assign ai_state = state_q;
endmodule
